// File: rtl/alu_tx_4b.sv
// alu_tx_4b
// ---------------------------------------------------------------------------
// Downstream TX stage of the 4-bit ALU datapath. Takes one 11-bit result
// (10-bit res plus carry) per res_valid/res_ready handshake and sends it out
// as a two-byte frame on an 8-bit valid/ready byte stream.
//
//   byte0 = {TAG, seq_f, 1'b0, carry, res[9:8]}   seq_f = SEQ_EN ? seq : 2'b00
//   byte1 = res[7:0]
//
// seq is a rolling 2-bit frame counter. It advances each time a frame's
// second byte is taken, so the host can spot dropped or repeated frames.
//
// Parameters
//   TAG        constant placed in byte0[7:6]
//   SEQ_EN     1: byte0[5:4] carries seq, 0: byte0[5:4] is forced to 2'b00
//
// Ports
//   clk        in   1   clock, all state on the rising edge
//   rst        in   1   asynchronous, active-high reset
//   res_valid  in   1   ALU result valid
//   res_ready  out  1   stage can take a result this cycle
//   res_q      in   10  ALU result
//   carry_q    in   1   ALU carry/borrow
//   tx_valid   out  1   tx_data holds a valid byte
//   tx_ready   in   1   consumer takes the byte this cycle
//   tx_data    out  8   frame byte (registered)
//   tx_busy    out  1   high while a frame is held
// ---------------------------------------------------------------------------
module alu_tx_4b #(
    parameter logic [1:0] TAG    = 2'b10,
    parameter bit         SEQ_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [9:0] res_q,
    input  logic       carry_q,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        S_HI = 2'b01,
        S_LO = 2'b10
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] seq;
    logic [1:0] seq_nxt;
    logic [9:0] res_r;
    logic       carry_r;
    logic [7:0] tx_data_r;
    logic [7:0] tx_data_nxt;
    logic       accept;
    logic       lo_taken;

    // byte0 is always built from the live inputs, because it is loaded at
    // the same edge at which the result is accepted.
    function automatic logic [7:0] make_byte0(input logic [1:0] s,
                                              input logic       c,
                                              input logic [1:0] hi);
        logic [1:0] seq_f;
        seq_f = SEQ_EN ? s : 2'b00;
        return {TAG, seq_f, 1'b0, c, hi};
    endfunction

    // The combinational path tx_ready -> res_ready is intentional. It lets a
    // new result be accepted in the same cycle that byte1 leaves, so frames
    // can follow each other with no idle gap.
    assign res_ready = !rst && ((state == IDLE) || ((state == S_LO) && tx_ready));
    assign accept    = res_valid && res_ready;
    assign lo_taken  = (state == S_LO) && tx_ready;

    assign tx_valid  = (state != IDLE);
    assign tx_busy   = (state != IDLE);
    assign tx_data   = tx_data_r;

    always_comb begin
        state_nxt   = state;
        seq_nxt     = seq;
        tx_data_nxt = tx_data_r;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = S_HI;
                    tx_data_nxt = make_byte0(seq, carry_q, res_q[9:8]);
                end
            end
            S_HI: begin
                if (tx_ready) begin
                    state_nxt   = S_LO;
                    tx_data_nxt = res_r[7:0];
                end
            end
            S_LO: begin
                if (lo_taken) begin
                    // The frame completes here. A frame accepted in this same
                    // cycle must already carry the advanced sequence number.
                    seq_nxt = seq + 2'd1;
                    if (accept) begin
                        state_nxt   = S_HI;
                        tx_data_nxt = make_byte0(seq_nxt, carry_q, res_q[9:8]);
                    end else begin
                        state_nxt   = IDLE;
                        tx_data_nxt = 8'h00;
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                tx_data_nxt = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            seq       <= 2'b00;
            tx_data_r <= 8'h00;
        end else begin
            state     <= state_nxt;
            seq       <= seq_nxt;
            tx_data_r <= tx_data_nxt;
        end
    end

    // The capture registers only load on accept, so a result that is
    // offered but not accepted never disturbs the frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_r   <= 10'h000;
            carry_r <= 1'b0;
        end else if (accept) begin
            res_r   <= res_q;
            carry_r <= carry_q;
        end
    end

    // carry_r sits in the capture register beside res_r. byte0 is always
    // built from the live inputs, so carry_r is never read back.
    logic unused_carry;
    assign unused_carry = carry_r;

endmodule

// File: tb/tb_alu_tx_4b.sv
// tb_alu_tx_4b
// ---------------------------------------------------------------------------
// Self-checking bench for alu_tx_4b. The bench drives directed frames and
// compares them against hand-computed bytes. It covers backpressure,
// back-to-back frames, sequence wrap (with SEQ_EN=1 and SEQ_EN=0), reset in
// the middle of a frame, and a randomized run checked by a scoreboard.
// Inputs change on the falling edge. Outputs are sampled 1ns later, so
// every sample sees the values that the next rising edge will act on.
// ---------------------------------------------------------------------------
module tb_alu_tx_4b;

    logic       clk;
    logic       rst;
    logic       res_valid;
    logic [9:0] res_q;
    logic       carry_q;
    logic       tx_ready;
    logic       res_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       res_ready2;
    logic       tx_valid2;
    logic [7:0] tx_data2;
    logic       tx_busy2;

    int tests;
    int failed;

    alu_tx_4b #(.TAG(2'b10), .SEQ_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
        .res_q(res_q), .carry_q(carry_q), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_busy(tx_busy)
    );

    alu_tx_4b #(.TAG(2'b10), .SEQ_EN(1'b0)) dut_noseq (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready2),
        .res_q(res_q), .carry_q(carry_q), .tx_valid(tx_valid2),
        .tx_ready(tx_ready), .tx_data(tx_data2), .tx_busy(tx_busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // This watchdog keeps the run from hanging if the DUT stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One cycle: drive the inputs at the falling edge, then let them settle.
    task automatic applyStimulus(input logic rv, input logic [9:0] rq,
                                 input logic cq, input logic tr);
        @(negedge clk);
        res_valid = rv;
        res_q     = rq;
        carry_q   = cq;
        tx_ready  = tr;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b1;
        res_valid = 1'b0;
        res_q     = 10'h000;
        carry_q   = 1'b0;
        tx_ready  = 1'b1;
        #1;
        checkOutput("reset tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("reset tx_data", 32'(tx_data), 32'h00);
        checkOutput("reset tx_busy", 32'(tx_busy), 32'd0);
        checkOutput("reset res_ready", 32'(res_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] expq[$];
    logic [1:0] model_seq;
    logic       held_valid;
    logic [7:0] held_byte;
    logic [7:0] exp_byte;

    initial begin
        tests     = 0;
        failed    = 0;
        rst       = 1'b1;
        res_valid = 1'b0;
        res_q     = 10'h000;
        carry_q   = 1'b0;
        tx_ready  = 1'b0;

        // T1: single frame 2A5/carry=1 -> 86, A5
        doReset();
        applyStimulus(1'b1, 10'h2A5, 1'b1, 1'b1);
        checkOutput("t1 ready idle", 32'(res_ready), 32'd1);
        checkOutput("t1 valid idle", 32'(tx_valid), 32'd0);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
        checkOutput("t1 byte0", 32'(tx_data), 32'h86);
        checkOutput("t1 busy hi", 32'(tx_busy), 32'd1);
        checkOutput("t1 ready hi", 32'(res_ready), 32'd0);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
        checkOutput("t1 byte1", 32'(tx_data), 32'hA5);
        checkOutput("t1 busy lo", 32'(tx_busy), 32'd1);
        checkOutput("t1 ready lo", 32'(res_ready), 32'd1);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
        checkOutput("t1 valid end", 32'(tx_valid), 32'd0);
        checkOutput("t1 data end", 32'(tx_data), 32'h00);
        checkOutput("t1 busy end", 32'(tx_busy), 32'd0);

        // T2: backpressure in S_HI for 3 cycles; an offered result is refused
        doReset();
        applyStimulus(1'b1, 10'h2A5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 10'h3FF, 1'b1, 1'b0);
            checkOutput("t2 hold data", 32'(tx_data), 32'h86);
            checkOutput("t2 hold valid", 32'(tx_valid), 32'd1);
            checkOutput("t2 hold ready", 32'(res_ready), 32'd0);
        end
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
        checkOutput("t2 release byte0", 32'(tx_data), 32'h86);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
        checkOutput("t2 byte1", 32'(tx_data), 32'hA5);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
        checkOutput("t2 valid end", 32'(tx_valid), 32'd0);

        // T3: the second result is accepted while byte1 is taken -> 90, 03
        doReset();
        applyStimulus(1'b1, 10'h2A5, 1'b1, 1'b1);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
        checkOutput("t3 byte0 a", 32'(tx_data), 32'h86);
        applyStimulus(1'b1, 10'h003, 1'b0, 1'b1);
        checkOutput("t3 byte1 a", 32'(tx_data), 32'hA5);
        checkOutput("t3 ready lo", 32'(res_ready), 32'd1);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
        checkOutput("t3 byte0 b", 32'(tx_data), 32'h90);
        checkOutput("t3 no gap", 32'(tx_valid), 32'd1);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
        checkOutput("t3 byte1 b", 32'(tx_data), 32'h03);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
        checkOutput("t3 valid end", 32'(tx_valid), 32'd0);

        // T4: five gapless frames, seq 0,1,2,3,0; the SEQ_EN=0 copy stays 0
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 10'(i), 1'b0, 1'b1);
            checkOutput("t4 ready", 32'(res_ready), 32'd1);
            applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
            exp_byte = {2'b10, 2'(i % 4), 4'b0000};
            checkOutput("t4 seq byte0", 32'(tx_data), 32'(exp_byte));
            checkOutput("t4 noseq byte0", 32'(tx_data2), 32'h80);
            checkOutput("t4 noseq valid", 32'(tx_valid2), 32'd1);
        end
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
        checkOutput("t4 last byte1", 32'(tx_data), 32'h04);
        checkOutput("t4 noseq byte1", 32'(tx_data2), 32'h04);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
        checkOutput("t4 noseq busy end", 32'(tx_busy2), 32'd0);
        checkOutput("t4 noseq ready end", 32'(res_ready2), 32'd1);

        // T5: reset in S_LO aborts the frame; the next frame restarts at seq 0
        doReset();
        applyStimulus(1'b1, 10'h155, 1'b0, 1'b1);
        applyStimulus(1'b1, 10'h155, 1'b0, 1'b1);
        applyStimulus(1'b1, 10'h155, 1'b0, 1'b1);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
        checkOutput("t5 second byte0", 32'(tx_data), 32'h91);
        @(posedge clk);
        #1;
        checkOutput("t5 in S_LO", 32'(tx_data), 32'h55);
        rst = 1'b1;
        #1;
        checkOutput("t5 abort valid", 32'(tx_valid), 32'd0);
        checkOutput("t5 abort data", 32'(tx_data), 32'h00);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
        checkOutput("t5 no byte1", 32'(tx_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 10'h2A5, 1'b1, 1'b1);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
        checkOutput("t5 seq restart", 32'(tx_data), 32'h86);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);

        // T6: random res_valid/tx_ready checked against a byte scoreboard
        doReset();
        model_seq  = 2'b00;
        held_valid = 1'b0;
        held_byte  = 8'h00;
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), 10'($urandom),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0));
            if (held_valid) begin
                checkOutput("t6 hold valid", 32'(tx_valid), 32'd1);
                checkOutput("t6 hold data", 32'(tx_data), 32'(held_byte));
            end
            if (tx_valid && tx_ready) begin
                if (expq.size() == 0) begin
                    checkOutput("t6 spurious byte", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("t6 order", 32'(tx_data), 32'(expq.pop_front()));
                end
            end
            if (res_valid && res_ready) begin
                expq.push_back({2'b10, model_seq, 1'b0, carry_q, res_q[9:8]});
                expq.push_back(res_q[7:0]);
                model_seq = model_seq + 2'd1;
            end
            held_valid = tx_valid && !tx_ready;
            held_byte  = tx_data;
        end
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
            if (tx_valid) begin
                if (expq.size() == 0) begin
                    checkOutput("t6 drain spurious", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("t6 drain order", 32'(tx_data), 32'(expq.pop_front()));
                end
            end
        end
        checkOutput("t6 queue empty", 32'(expq.size()), 32'd0);
        checkOutput("t6 idle at end", 32'(tx_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
